// File: rtl/vx_pending_bank_pkg.sv
// Shared types for the pending-request bank: drain FSM states and saturation result.
package vx_pending_bank_pkg;

  // Drain (fence) handshake states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } drain_state_e;

  // Outcome of one counter update before it is committed
  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_OVF  = 2'd1,
    SAT_UDF  = 2'd2
  } sat_e;

endpackage

// File: rtl/vx_pending_bank_chan.sv
// One saturating outstanding-request counter with flags, clear and sticky error bits.
module vx_pending_bank_chan
  import vx_pending_bank_pkg::*;
#(
  parameter int unsigned SIZE      = 16,
  parameter int unsigned INCRW     = 2,
  parameter int unsigned DECRW     = 2,
  parameter int unsigned ALM_FULL  = SIZE - 1,
  parameter int unsigned ALM_EMPTY = 1,
  parameter int unsigned SIZEW     = $clog2(SIZE + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INCRW-1:0] incr_i,
  input  logic [DECRW-1:0] decr_i,
  input  logic             clear_i,
  output logic [SIZEW-1:0] size_o,
  output logic             empty_o,
  output logic             alm_empty_o,
  output logic             full_o,
  output logic             alm_full_o,
  output logic             err_ovf_o,
  output logic             err_udf_o,
  output logic             empty_nxt_c,
  output logic             full_nxt_c
);

  // Two extra bits hold both the positive excess and the sign of the net update
  localparam int unsigned NW = SIZEW + 2;

  logic signed [NW-1:0] sum_s;
  sat_e                 sat;
  logic [SIZEW-1:0]     size_d, size_q;
  logic                 ovf_d, ovf_q, udf_d, udf_q;
  logic                 empty_q, alm_empty_q, full_q, alm_full_q;

  // Net the update, saturate, apply clear priority
  always_comb begin
    sum_s  = $signed(NW'(size_q)) + $signed(NW'(incr_i)) - $signed(NW'(decr_i));
    sat    = SAT_NONE;
    size_d = SIZEW'(sum_s);
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (sum_s > $signed(NW'(SIZE))) begin
      sat    = SAT_OVF;
      size_d = SIZEW'(SIZE);
    end else if (sum_s < $signed(NW'(0))) begin
      sat    = SAT_UDF;
      size_d = '0;
    end
    if (sat == SAT_OVF) ovf_d = 1'b1;
    if (sat == SAT_UDF) udf_d = 1'b1;
    if (clear_i) begin
      size_d = '0;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
    end
  end

  assign empty_nxt_c = (size_d == '0);
  assign full_nxt_c  = (size_d == SIZEW'(SIZE));

  // Count, flags and error bits, all derived from the next value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_q      <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      empty_q     <= 1'b1;
      alm_empty_q <= 1'b1;
      full_q      <= 1'b0;
      alm_full_q  <= 1'b0;
    end else begin
      size_q      <= size_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      empty_q     <= empty_nxt_c;
      alm_empty_q <= (size_d <= SIZEW'(ALM_EMPTY));
      full_q      <= full_nxt_c;
      alm_full_q  <= (size_d >= SIZEW'(ALM_FULL));
    end
  end

  assign size_o      = size_q;
  assign empty_o     = empty_q;
  assign alm_empty_o = alm_empty_q;
  assign full_o      = full_q;
  assign alm_full_o  = alm_full_q;
  assign err_ovf_o   = ovf_q;
  assign err_udf_o   = udf_q;

endmodule

// File: rtl/vx_pending_bank.sv
// Bank of outstanding-request counters with aggregate flags and a drain (fence) handshake.
module vx_pending_bank
  import vx_pending_bank_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned SIZE         = 16,
  parameter int unsigned INCRW        = 2,
  parameter int unsigned DECRW        = 2,
  parameter int unsigned ALM_FULL     = SIZE - 1,
  parameter int unsigned ALM_EMPTY    = 1,
  parameter int unsigned SIZEW        = $clog2(SIZE + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CHANNELS*INCRW-1:0]   incr,
  input  logic [NUM_CHANNELS*DECRW-1:0]   decr,
  input  logic [NUM_CHANNELS-1:0]         clear,
  input  logic                            drain_valid,
  output logic                            drain_ready,
  output logic                            incr_stall,
  output logic [NUM_CHANNELS*SIZEW-1:0]   size,
  output logic [NUM_CHANNELS-1:0]         empty,
  output logic [NUM_CHANNELS-1:0]         alm_empty,
  output logic [NUM_CHANNELS-1:0]         full,
  output logic [NUM_CHANNELS-1:0]         alm_full,
  output logic                            all_empty,
  output logic                            any_full,
  output logic [NUM_CHANNELS-1:0]         err_ovf,
  output logic [NUM_CHANNELS-1:0]         err_udf
);

  logic [NUM_CHANNELS-1:0] empty_nxt, full_nxt;
  logic                    all_empty_q, any_full_q;
  logic                    drain_ready_q, incr_stall_q;
  drain_state_e            state_d, state_q;

  // Independent per-channel counters
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    vx_pending_bank_chan #(
      .SIZE      (SIZE),
      .INCRW     (INCRW),
      .DECRW     (DECRW),
      .ALM_FULL  (ALM_FULL),
      .ALM_EMPTY (ALM_EMPTY),
      .SIZEW     (SIZEW)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .incr_i      (incr[g*INCRW +: INCRW]),
      .decr_i      (decr[g*DECRW +: DECRW]),
      .clear_i     (clear[g]),
      .size_o      (size[g*SIZEW +: SIZEW]),
      .empty_o     (empty[g]),
      .alm_empty_o (alm_empty[g]),
      .full_o      (full[g]),
      .alm_full_o  (alm_full[g]),
      .err_ovf_o   (err_ovf[g]),
      .err_udf_o   (err_udf[g]),
      .empty_nxt_c (empty_nxt[g]),
      .full_nxt_c  (full_nxt[g])
    );
  end

  // Drain FSM next state; abort whenever the requester withdraws
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (drain_valid) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain_valid)     state_d = ST_IDLE;
        else if (all_empty_q) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;  // handshake completes or aborts here either way
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, aggregates and handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      all_empty_q   <= 1'b1;
      any_full_q    <= 1'b0;
      drain_ready_q <= 1'b0;
      incr_stall_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      all_empty_q   <= &empty_nxt;
      any_full_q    <= |full_nxt;
      drain_ready_q <= (state_d == ST_DONE);
      incr_stall_q  <= (state_d != ST_IDLE);
    end
  end

  assign all_empty   = all_empty_q;
  assign any_full    = any_full_q;
  assign drain_ready = drain_ready_q;
  assign incr_stall  = incr_stall_q;

endmodule

// File: tb/tb_vx_pending_bank.sv
// Directed table-driven bench for vx_pending_bank (default parameters).
module tb_vx_pending_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  incr, decr;
  logic [3:0]  clear;
  logic        drain_valid;
  logic        drain_ready, incr_stall;
  logic [19:0] size;
  logic [3:0]  empty, alm_empty, full, alm_full, err_ovf, err_udf;
  logic        all_empty, any_full;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vx_pending_bank dut (
    .clk         (clk),
    .reset       (reset),
    .incr        (incr),
    .decr        (decr),
    .clear       (clear),
    .drain_valid (drain_valid),
    .drain_ready (drain_ready),
    .incr_stall  (incr_stall),
    .size        (size),
    .empty       (empty),
    .alm_empty   (alm_empty),
    .full        (full),
    .alm_full    (alm_full),
    .all_empty   (all_empty),
    .any_full    (any_full),
    .err_ovf     (err_ovf),
    .err_udf     (err_udf)
  );

  typedef struct packed {
    logic [7:0]  incr;
    logic [7:0]  decr;
    logic [3:0]  clr;
    logic [19:0] sz;
    logic [3:0]  ovf;
    logic [3:0]  udf;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic [7:0] i, input logic [7:0] d, input logic [3:0] c,
                              input int s3, input int s2, input int s1, input int s0,
                              input logic [3:0] o, input logic [3:0] u);
    vec_t v;
    v.incr = i;
    v.decr = d;
    v.clr  = c;
    v.sz   = {5'(s3), 5'(s2), 5'(s1), 5'(s0)};
    v.ovf  = o;
    v.udf  = u;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the edge
  task automatic step(input logic [7:0] i, input logic [7:0] d, input logic [3:0] c);
    @(negedge clk);
    incr  = i;
    decr  = d;
    clear = c;
    @(posedge clk);
    #1;
    incr  = '0;
    decr  = '0;
    clear = '0;
  endtask

  // Check every counter output against an expected size/error snapshot
  task automatic chk_state(input string tag, input logic [19:0] sz,
                           input logic [3:0] o, input logic [3:0] u);
    logic [3:0] e_empty, e_alme, e_full, e_almf;
    int s;
    for (int ch = 0; ch < 4; ch++) begin
      s = int'(sz[ch*5 +: 5]);
      e_empty[ch] = (s == 0);
      e_full[ch]  = (s == 16);
      e_alme[ch]  = (s <= 1);
      e_almf[ch]  = (s >= 15);
    end
    chk({tag, " size"},      32'(size),      32'(sz));
    chk({tag, " empty"},     32'(empty),     32'(e_empty));
    chk({tag, " alm_empty"}, 32'(alm_empty), 32'(e_alme));
    chk({tag, " full"},      32'(full),      32'(e_full));
    chk({tag, " alm_full"},  32'(alm_full),  32'(e_almf));
    chk({tag, " all_empty"}, 32'(all_empty), 32'(&e_empty));
    chk({tag, " any_full"},  32'(any_full),  32'(|e_full));
    chk({tag, " err_ovf"},   32'(err_ovf),   32'(o));
    chk({tag, " err_udf"},   32'(err_udf),   32'(u));
  endtask

  initial begin
    // incr/decr packed as {ch3, ch2, ch1, ch0}; expected sizes listed ch3..ch0
    vecs[0]  = mk({2'd0,2'd0,2'd0,2'd3}, 8'h00, 4'b0000, 0, 0, 0,  3, 4'b0000, 4'b0000);
    vecs[1]  = mk({2'd0,2'd1,2'd2,2'd3}, 8'h00, 4'b0000, 0, 1, 2,  6, 4'b0000, 4'b0000);
    vecs[2]  = mk({2'd3,2'd3,2'd3,2'd3}, 8'h00, 4'b0000, 3, 4, 5,  9, 4'b0000, 4'b0000);
    vecs[3]  = mk({2'd0,2'd0,2'd3,2'd3}, {2'd0,2'd0,2'd0,2'd1}, 4'b0000, 3, 4, 8, 11, 4'b0000, 4'b0000);
    vecs[4]  = mk({2'd0,2'd0,2'd0,2'd3}, 8'h00, 4'b0000, 3, 4, 8, 14, 4'b0000, 4'b0000);
    vecs[5]  = mk({2'd0,2'd0,2'd0,2'd3}, {2'd0,2'd0,2'd0,2'd1}, 4'b0000, 3, 4, 8, 16, 4'b0000, 4'b0000);
    vecs[6]  = mk({2'd0,2'd0,2'd0,2'd1}, 8'h00, 4'b0000, 3, 4, 8, 16, 4'b0001, 4'b0000);
    vecs[7]  = mk({2'd0,2'd1,2'd0,2'd0}, {2'd3,2'd0,2'd0,2'd0}, 4'b0000, 0, 5, 8, 16, 4'b0001, 4'b0000);
    vecs[8]  = mk({2'd0,2'd2,2'd0,2'd0}, {2'd0,2'd0,2'd1,2'd0}, 4'b0100, 0, 0, 7, 16, 4'b0001, 4'b0000);
    vecs[9]  = mk({2'd0,2'd1,2'd0,2'd0}, {2'd0,2'd0,2'd0,2'd1}, 4'b0000, 0, 1, 7, 15, 4'b0001, 4'b0000);
    vecs[10] = mk(8'h00, {2'd0,2'd2,2'd0,2'd0}, 4'b0000, 0, 0, 7, 15, 4'b0001, 4'b0100);
    vecs[11] = mk(8'h00, 8'h00, 4'b0101, 0, 0, 7,  0, 4'b0000, 4'b0000);
    vecs[12] = mk(8'h00, {2'd1,2'd0,2'd3,2'd0}, 4'b0000, 0, 0, 4, 0, 4'b0000, 4'b1000);
    vecs[13] = mk({2'd2,2'd0,2'd0,2'd0}, {2'd2,2'd0,2'd3,2'd0}, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b1000);
    vecs[14] = mk(8'h00, {2'd0,2'd0,2'd2,2'd0}, 4'b1000, 0, 0, 0, 0, 4'b0000, 4'b0010);
    vecs[15] = mk(8'h00, 8'h00, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000);

    reset       = 1'b1;
    incr        = '0;
    decr        = '0;
    clear       = '0;
    drain_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 20'h0, 4'b0000, 4'b0000);
    chk("reset drain_ready", 32'(drain_ready), 32'd0);
    chk("reset incr_stall",  32'(incr_stall),  32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 16; k++) begin
      step(vecs[k].incr, vecs[k].decr, vecs[k].clr);
      chk_state($sformatf("vec%0d", k), vecs[k].sz, vecs[k].ovf, vecs[k].udf);
    end

    // Fence with outstanding work on two channels
    step({2'd0,2'd0,2'd1,2'd2}, 8'h00, 4'b0000);
    chk("drain pre size", 32'(size), 32'({5'd0,5'd0,5'd1,5'd2}));
    @(negedge clk);
    drain_valid = 1'b1;
    @(posedge clk); #1;
    chk("drain stall",     32'(incr_stall),  32'd1);
    chk("drain not ready", 32'(drain_ready), 32'd0);
    step(8'h00, 8'h00, 4'b0000);
    chk("drain waiting",   32'(drain_ready), 32'd0);
    step(8'h00, {2'd0,2'd0,2'd1,2'd2}, 4'b0000);
    chk("drain all_empty", 32'(all_empty),   32'd1);
    chk("drain ready lag", 32'(drain_ready), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    chk("drain ready",     32'(drain_ready), 32'd1);
    chk("drain done stall",32'(incr_stall),  32'd1);
    @(negedge clk);
    drain_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain idle stall", 32'(incr_stall),  32'd0);
    chk("drain idle ready", 32'(drain_ready), 32'd0);

    // Minimum two-cycle fence when already empty
    @(negedge clk);
    drain_valid = 1'b1;
    @(posedge clk); #1;
    chk("fast fence stall", 32'(incr_stall),  32'd1);
    chk("fast fence ready0",32'(drain_ready), 32'd0);
    @(posedge clk); #1;
    chk("fast fence ready1",32'(drain_ready), 32'd1);
    @(negedge clk);
    drain_valid = 1'b0;
    @(posedge clk); #1;
    chk("fast fence idle", 32'(incr_stall), 32'd0);

    // Async reset in the middle of a fence
    step({2'd0,2'd0,2'd0,2'd3}, 8'h00, 4'b0000);
    step({2'd0,2'd0,2'd0,2'd3}, 8'h00, 4'b0000);
    step({2'd0,2'd0,2'd0,2'd1}, 8'h00, 4'b0000);
    chk("mid size 7", 32'(size), 32'd7);
    @(negedge clk);
    drain_valid = 1'b1;
    @(posedge clk); #1;
    chk("mid stall", 32'(incr_stall), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_state("async reset", 20'h0, 4'b0000, 4'b0000);
    chk("async stall", 32'(incr_stall),  32'd0);
    chk("async ready", 32'(drain_ready), 32'd0);
    @(negedge clk);
    drain_valid = 1'b0;
    @(posedge clk); #1;
    chk("held reset ready", 32'(drain_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(8'h00, 8'h00, 4'b0000);
    chk("post reset ready", 32'(drain_ready), 32'd0);
    chk("post reset stall", 32'(incr_stall),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
